rv_alu: RTL and testbench
=========================

Name: rv_alu

Overview:
- RV32I integer execution unit of the single-cycle core; consumes the operand-mux outputs and the control-unit operation select.
- Combinational path produces the result written to the register file in the same cycle, plus compare flags used for branch resolution.
- A clocked capture stage holds the last enabled result and flags, for debug and trace.

Parameters:
- WIDTH, 32, operand/result width. Must be a power of two, ≥8. Shift amount uses the low log2(WIDTH) bits of b.

Ports:
- clk  input  1  clock; capture stage updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears the capture stage only.
- sel  input  3  operation select; encoding under Behaviour.
- L_R  input  1  shift direction: 0 = left, 1 = right.
- S_U  input  1  compare signedness: 0 = signed, 1 = unsigned.
- A_L  input  1  right-shift type: 0 = arithmetic, 1 = logical.
- Add_Sub  input  1  0 = a+b, 1 = a-b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cap_en  input  1  load capture stage this cycle.
- result  output  WIDTH  combinational result.
- LESS  output  1  combinational: a<b, per S_U.
- IS_ZERO  output  1  combinational: a==b.
- result_q  output  WIDTH  registered result.
- less_q  output  1  registered LESS.
- zero_q  output  1  registered IS_ZERO.

Behaviour:
- Combinational outputs: no latency, no clock or reset dependence.
- sel encoding:
  - 000: Add_Sub ? a-b : a+b, modulo 2^WIDTH.
  - 001: shift. L_R=0 gives a<<sh. L_R=1 gives a>>sh, arithmetic if A_L=0, logical if A_L=1.
  - 010: zero-extended LESS (1 or 0).
  - 011: b passthrough (LUI path).
  - 100: a^b.
  - 101: right shift a>>sh, L_R ignored, type per A_L.
  - 110: a|b.
  - 111: a&b.
- sh = b[log2(WIDTH)-1:0]; upper bits of b are ignored. sh=0 returns a unchanged.
- Arithmetic right shift replicates a[WIDTH-1].
- LESS and IS_ZERO are valid for every sel value; they do not depend on Add_Sub.
  - Signed compare uses two's complement.
  - Unsigned compare is a plain magnitude compare.
- Add/sub wrap silently; no trap.
- Control inputs unused by the selected operation have no effect on result.
- Capture stage:
  - rst low (asynchronous, immediate): result_q=0, less_q=0, zero_q=0.
  - While rst is low, the stage holds 0 regardless of clk or cap_en.
  - On a rising clk edge with rst high and cap_en=1: result_q, less_q, zero_q load result, LESS, IS_ZERO (1-cycle latency).
  - With cap_en=0: values hold.
  - Reset deasserting on the same edge as cap_en=1: no load that edge. The first load is on the next edge.
- No internal state other than the capture stage.

Optional Feature:
- Macro ALU_FLAGS_EXT_EN.
- Defined:
  - Adds outputs carry (1) and overflow (1), valid only when sel=000, 0 otherwise.
  - carry: carry-out of a+b, or not-borrow of a-b (i.e. a>=b unsigned).
  - overflow: signed two's-complement overflow of the selected add/sub.
  - Both are also captured into carry_q and overflow_q, with reset 0 and the same cap_en rule.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- sel=000, Add_Sub=0, a=0xFFFFFFFF, b=1 → result=0. Add_Sub=1, a=5, b=7 → result=0xFFFFFFFE.
- sel=010, a=0xFFFFFFFF, b=1: S_U=0 → result=1, LESS=1. S_U=1 → result=0, LESS=0. a=b=0x1234 → IS_ZERO=1.
- sel=001, a=0x80000000, b=0x24 (sh=4):
  - L_R=1, A_L=0 → 0xF8000000.
  - L_R=1, A_L=1 → 0x08000000.
  - L_R=0 → 0x00000000.
- sel=011/100/110/111, a=0xF0F0F0F0, b=0x0FF00FF0 → 0x0FF00FF0 / 0xFF00FF00 / 0xFFF0FFF0 / 0x00F000F0.
- Capture:
  - cap_en=1, result=0x55 at edge → result_q=0x55 next cycle.
  - cap_en=0 with new inputs → result_q holds 0x55.
  - rst low between edges → result_q=0 immediately.
- ALU_FLAGS_EXT_EN:
  - a=0x7FFFFFFF, b=1 add → overflow=1, carry=0.
  - a=0, b=1 sub → carry=0, overflow=0.

Source files
------------

// File: rtl/rv_alu.sv
// rv_alu: RV32I integer execution unit for the single-cycle core.
// Combinational result and compare flags feed the register file and branch
// logic in the same cycle. A clocked capture stage holds the last enabled
// result and flags for debug and trace.
// Optional feature macro: ALU_FLAGS_EXT_EN adds carry/overflow outputs for
// sel=000, with registered copies carry_q/overflow_q.
module rv_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sel,
  input  logic             L_R,
  input  logic             S_U,
  input  logic             A_L,
  input  logic             Add_Sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cap_en,
  output logic [WIDTH-1:0] result,
  output logic             LESS,
  output logic             IS_ZERO,
`ifdef ALU_FLAGS_EXT_EN
  output logic             carry,
  output logic             overflow,
  output logic             carry_q,
  output logic             overflow_q,
`endif
  output logic [WIDTH-1:0] result_q,
  output logic             less_q,
  output logic             zero_q
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [ShW-1:0]   sh;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;

  assign sh = b[ShW-1:0];

  // Subtraction is a + ~b + 1, so one adder serves both and the carry-out
  // doubles as the not-borrow flag.
  assign b_eff = Add_Sub ? ~b : b;

`ifdef ALU_FLAGS_EXT_EN
  logic sum_co;
  logic add_ovf;

  // Shared adder with carry-out and signed-overflow detection.
  always_comb begin
    {sum_co, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Add_Sub};
    add_ovf       = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  assign carry    = (sel == 3'b000) ? sum_co  : 1'b0;
  assign overflow = (sel == 3'b000) ? add_ovf : 1'b0;
`else
  assign sum = a + b_eff + {{(WIDTH-1){1'b0}}, Add_Sub};
`endif

  assign shl = a << sh;
  assign shr = A_L ? (a >> sh) : WIDTH'($signed(a) >>> sh);

  // Compare flags are independent of sel and Add_Sub.
  always_comb begin
    LESS    = S_U ? (a < b) : ($signed(a) < $signed(b));
    IS_ZERO = (a == b);
  end

  // Result select.
  always_comb begin
    result = '0;
    unique case (sel)
      3'b000: result = sum;
      3'b001: result = L_R ? shr : shl;
      3'b010: result = {{(WIDTH-1){1'b0}}, LESS};
      3'b011: result = b;
      3'b100: result = a ^ b;
      3'b101: result = shr;
      3'b110: result = a | b;
      3'b111: result = a & b;
      default: result = '0;
    endcase
  end

  // Capture stage: async clear; a reset released on a load edge still holds
  // the flop in reset for that edge, so the first load is the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      less_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (cap_en) begin
      result_q <= result;
      less_q   <= LESS;
      zero_q   <= IS_ZERO;
    end
  end

`ifdef ALU_FLAGS_EXT_EN
  // Capture of the extended add/sub flags, same load rule as above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (cap_en) begin
      carry_q    <= carry;
      overflow_q <= overflow;
    end
  end
`endif

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu (WIDTH=32). Flag checks compile in
// only when ALU_FLAGS_EXT_EN is defined.
module tb_rv_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  sel;
  logic        L_R;
  logic        S_U;
  logic        A_L;
  logic        Add_Sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        cap_en;
  logic [31:0] result;
  logic        LESS;
  logic        IS_ZERO;
  logic [31:0] result_q;
  logic        less_q;
  logic        zero_q;
`ifdef ALU_FLAGS_EXT_EN
  logic        carry;
  logic        overflow;
  logic        carry_q;
  logic        overflow_q;
`endif

  int n_tests;
  int n_fail;

  rv_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .L_R        (L_R),
    .S_U        (S_U),
    .A_L        (A_L),
    .Add_Sub    (Add_Sub),
    .a          (a),
    .b          (b),
    .cap_en     (cap_en),
    .result     (result),
    .LESS       (LESS),
    .IS_ZERO    (IS_ZERO),
`ifdef ALU_FLAGS_EXT_EN
    .carry      (carry),
    .overflow   (overflow),
    .carry_q    (carry_q),
    .overflow_q (overflow_q),
`endif
    .result_q   (result_q),
    .less_q     (less_q),
    .zero_q     (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a full operation on the falling edge, then let it settle.
  task automatic drive(input logic [2:0] s, input logic lr, input logic su, input logic al,
                       input logic as, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    sel = s; L_R = lr; S_U = su; A_L = al; Add_Sub = as; a = va; b = vb;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; cap_en = 1'b0;
    sel = '0; L_R = 0; S_U = 0; A_L = 0; Add_Sub = 0; a = '0; b = '0;

    // Reset state
    #2;
    check("rst_result_q", 64'(result_q), 64'h0);
    check("rst_less_q",   64'(less_q),   64'h0);
    check("rst_zero_q",   64'(zero_q),   64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Add / sub
    drive(3'b000, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1);
    check("add_wrap", 64'(result), 64'h0);
    check("add_zero_flag", 64'(IS_ZERO), 64'h0);
    drive(3'b000, 0, 0, 0, 1, 32'd5, 32'd7);
    check("sub_neg", 64'(result), 64'hFFFF_FFFE);
    check("sub_less", 64'(LESS), 64'h1);

    // Set-less-than
    drive(3'b010, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1);
    check("slt_signed", 64'(result), 64'h1);
    check("less_signed", 64'(LESS), 64'h1);
    drive(3'b010, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'h1);
    check("slt_unsigned", 64'(result), 64'h0);
    check("less_unsigned", 64'(LESS), 64'h0);
    drive(3'b010, 0, 0, 0, 1, 32'h1234, 32'h1234);
    check("eq_zero", 64'(IS_ZERO), 64'h1);
    check("eq_less", 64'(LESS), 64'h0);

    // Shifts (sh = 4 from b = 0x24)
    drive(3'b001, 1, 0, 0, 0, 32'h8000_0000, 32'h24);
    check("sra", 64'(result), 64'hF800_0000);
    drive(3'b001, 1, 0, 1, 0, 32'h8000_0000, 32'h24);
    check("srl", 64'(result), 64'h0800_0000);
    drive(3'b001, 0, 0, 0, 0, 32'h8000_0000, 32'h24);
    check("sll", 64'(result), 64'h0);
    drive(3'b001, 0, 0, 0, 0, 32'h1234_5678, 32'h24);
    check("sll_small", 64'(result), 64'h2345_6780);
    drive(3'b101, 0, 0, 0, 0, 32'h8000_0000, 32'h24);
    check("sel101_sra", 64'(result), 64'hF800_0000);
    drive(3'b101, 0, 0, 1, 0, 32'h8000_0000, 32'h24);
    check("sel101_srl", 64'(result), 64'h0800_0000);
    drive(3'b001, 0, 0, 0, 0, 32'h1234_5678, 32'h20);
    check("sh_zero", 64'(result), 64'h1234_5678);

    // Passthrough and logic ops
    drive(3'b011, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("lui", 64'(result), 64'h0FF0_0FF0);
    drive(3'b100, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("xor", 64'(result), 64'hFF00_FF00);
    drive(3'b110, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("or", 64'(result), 64'hFFF0_FFF0);
    drive(3'b111, 0, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and", 64'(result), 64'h00F0_00F0);

    // Capture: load, hold, async clear, hold-in-reset, reload
    drive(3'b011, 0, 0, 0, 0, 32'h0, 32'h55);
    cap_en = 1'b1;
    @(posedge clk); #1;
    check("cap_load", 64'(result_q), 64'h55);
    check("cap_less", 64'(less_q), 64'h1);
    check("cap_zero", 64'(zero_q), 64'h0);
    drive(3'b000, 0, 0, 0, 0, 32'h7, 32'h7);
    cap_en = 1'b0;
    @(posedge clk); #1;
    check("cap_hold", 64'(result_q), 64'h55);
    check("cap_hold_less", 64'(less_q), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_clr", 64'(result_q), 64'h0);
    check("async_clr_less", 64'(less_q), 64'h0);
    cap_en = 1'b1;
    @(posedge clk); #1;
    check("rst_hold", 64'(result_q), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reload", 64'(result_q), 64'hE);
    check("reload_zero", 64'(zero_q), 64'h1);
    cap_en = 1'b0;

`ifdef ALU_FLAGS_EXT_EN
    drive(3'b000, 0, 0, 0, 0, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf", 64'(overflow), 64'h1);
    check("add_carry", 64'(carry), 64'h0);
    cap_en = 1'b1;
    @(posedge clk); #1;
    check("ovf_q", 64'(overflow_q), 64'h1);
    cap_en = 1'b0;
    drive(3'b000, 0, 0, 0, 1, 32'h0, 32'h1);
    check("sub_carry", 64'(carry), 64'h0);
    check("sub_ovf", 64'(overflow), 64'h0);
    drive(3'b000, 0, 0, 0, 1, 32'h5, 32'h3);
    check("sub_noborrow", 64'(carry), 64'h1);
    drive(3'b000, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1);
    check("add_carry_out", 64'(carry), 64'h1);
    drive(3'b110, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h1);
    check("flags_gated", 64'(carry), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
